cmul_sched: RTL and testbench
=============================

Name: cmul_sched

Overview:
- Sequences one complex twiddle multiply, (ar + j·ai)·(wr + j·wi), for the FFT butterfly.
- Uses a single shared sign-magnitude shift-add multiplier core for all four real products, one product at a time.
- Converts each product to two's complement and accumulates it into the real or imaginary result.
- Sits between the butterfly operand/twiddle fetch and the butterfly adders; valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand width in sign-magnitude: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude.
- OUT_W, 2*WIDTH, result width, two's complement (derived; not to be overridden).

Ports:
- clkin  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  high only in IDLE.
- ar, ai  in  WIDTH each  data operand, sign-magnitude.
- wr, wi  in  WIDTH each  twiddle operand, sign-magnitude.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- re_out, im_out  out  OUT_W each  result, two's complement.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; product index, accumulators, re_out and im_out are cleared to 0.
  - out_valid=0, busy=0; in_ready=1 once reset releases. The core is reset too.
- States and transitions:
  - IDLE: on in_valid && in_ready, capture ar/ai/wr/wi, clear both accumulators, set idx=0, go to ISSUE.
  - ISSUE: hold mul_start high for exactly one cycle with the operand pair for idx, go to WAIT.
  - WAIT: on mul_done, accumulate the product. If idx==3 go to DONE, otherwise idx++ and go to ISSUE.
  - DONE: out_valid=1. On out_ready, go to IDLE. Accumulators and outputs hold until the next acceptance.
- Product order, fixed:
  - idx0: ar·wr added to re.
  - idx1: ai·wi subtracted from re.
  - idx2: ar·wi added to im.
  - idx3: ai·wr added to im.
- Per-product arithmetic:
  - Effective sign = sa ^ sb ^ subtract-flag.
  - The (2*WIDTH-2)-bit magnitude is zero-extended to OUT_W and negated when the effective sign is 1.
  - A zero magnitude is always 0, so -0 operands (e.g. 8'h80) contribute 0.
  - Accumulation is OUT_W wide. Overflow is impossible: |sum| ≤ 2·(2^(WIDTH-1)-1)^2 < 2^(OUT_W-1).
- Core timing:
  - On the start edge the core loads the a magnitude, the b magnitude, and acc=0.
  - Each following edge while b≠0: add a if b[0]=1, then a<<=1 and b>>=1.
  - When b==0, mul_done pulses for one cycle.
  - n = bit-length of |b| (0 for |b|=0). Each product takes n+2 cycles from the ISSUE edge to the edge after mul_done.
- Latency: from the acceptance edge to out_valid rising is 2·n(wr) + 2·n(wi) + 8 cycles. Worst case is 4·WIDTH+4.
- Handshake edge cases:
  - in_valid while busy is ignored; operands are not re-sampled.
  - out_valid stays high with stable data under out_ready=0 backpressure.
  - A new request is never accepted in the same cycle as output completion; IDLE lasts at least one cycle.
- Reset mid-operation: the sequence is abandoned immediately, with no out_valid pulse. All state and outputs return to reset values.

Decomposition:
- Shared package (fft_pkg) holds:
  - the sign-magnitude field helpers (sign bit index, magnitude width);
  - the state encoding enum;
  - the product-order table (operand select, destination, subtract flag per idx).
- One sub-module, smag_mul_core:
  - resettable sign-magnitude shift-add multiplier with start/done;
  - outputs sign = sa^sb and a (2*WIDTH-2)-bit magnitude;
  - iterates LSB-first and terminates early when the remaining multiplier is 0.

Test Plan:
- WIDTH=8: ar=+2, ai=+1, wr=+3, wi=+0 → re_out=6, im_out=3; out_valid 12 cycles after acceptance.
- ar=+5, ai=-3, wr=-4, wi=+7 → re_out=1, im_out=47; latency 20 cycles.
- ar=ai=wr=-127, wi=+127 → re_out=32258, im_out=0; latency 36 (worst case), no overflow.
- wr=8'h80 (-0), wi=8'h00, ar=+9, ai=-9 → re_out=0, im_out=0; latency 8.
- out_ready=0 for 10 cycles in DONE, with in_valid held high and new operands → outputs stable, in_ready=0. First request completes, then the second is accepted and gives correct results.
- rst_n pulsed low during WAIT of idx2 → out_valid never rises, outputs 0, in_ready=1 after release. The next request produces correct results.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding, sign-magnitude helpers and product-order table
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // a_sel: 0=ar 1=ai, b_sel: 0=wr 1=wi, dst_im: 0=re 1=im, sub: negate the product
  typedef struct packed {
    logic a_sel;
    logic b_sel;
    logic dst_im;
    logic sub;
  } prod_ctl_t;

  function automatic int sm_sign_bit(input int width);
    return width - 1;
  endfunction

  function automatic int sm_mag_w(input int width);
    return width - 1;
  endfunction

  function automatic prod_ctl_t prod_ctl(input logic [1:0] idx);
    prod_ctl_t c;
    case (idx)
      2'd0:    c = '{a_sel: 1'b0, b_sel: 1'b0, dst_im: 1'b0, sub: 1'b0};
      2'd1:    c = '{a_sel: 1'b1, b_sel: 1'b1, dst_im: 1'b0, sub: 1'b1};
      2'd2:    c = '{a_sel: 1'b0, b_sel: 1'b1, dst_im: 1'b1, sub: 1'b0};
      default: c = '{a_sel: 1'b1, b_sel: 1'b0, dst_im: 1'b1, sub: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/smag_mul_core.sv
// rtl/smag_mul_core.sv - sign-magnitude shift-add multiplier, LSB-first with early exit
module smag_mul_core
  import fft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic                 o_sign,
  output logic [2*WIDTH-3:0]   o_mag
);

  localparam int SB = sm_sign_bit(WIDTH);
  localparam int MW = sm_mag_w(WIDTH);
  localparam int PW = 2 * MW;

  logic [PW-1:0] r_a;
  logic [PW-1:0] r_acc;
  logic [MW-1:0] r_b;
  logic          r_sign;
  logic          r_run;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_sign <= 1'b0;
      r_run  <= 1'b0;
    end else if (i_start) begin
      r_a    <= {{(PW-MW){1'b0}}, i_a[MW-1:0]};
      r_b    <= i_b[MW-1:0];
      r_acc  <= '0;
      r_sign <= i_a[SB] ^ i_b[SB];
      r_run  <= 1'b1;
    end else if (r_run) begin
      // Stop as soon as no multiplier bits remain; done is seen for exactly one cycle
      if (r_b != '0) begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign o_done = r_run && (r_b == '0);
  assign o_sign = r_sign;
  assign o_mag  = r_acc;

endmodule

// File: rtl/cmul_sched.sv
// rtl/cmul_sched.sv - sequences the four real products of one complex twiddle multiply
module cmul_sched
  import fft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     ar,
  input  logic [WIDTH-1:0]     ai,
  input  logic [WIDTH-1:0]     wr,
  input  logic [WIDTH-1:0]     wi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   re_out,
  output logic [2*WIDTH-1:0]   im_out,
  output logic                 busy
);

  localparam int OUT_W = 2 * WIDTH;
  localparam int PW    = 2 * sm_mag_w(WIDTH);

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [WIDTH-1:0]   r_ar, r_ai, r_wr, r_wi;
  logic [OUT_W-1:0]   r_re, r_im;
  logic               r_in_ready, r_out_valid, r_busy, r_mul_start;

  prod_ctl_t          w_ctl;
  logic [WIDTH-1:0]   w_op_a, w_op_b;
  logic               w_mul_done, w_mul_sign, w_neg;
  logic [PW-1:0]      w_mul_mag;
  logic [OUT_W-1:0]   w_mag_ext, w_term;

  assign w_ctl  = prod_ctl(r_idx);
  assign w_op_a = w_ctl.a_sel ? r_ai : r_ar;
  assign w_op_b = w_ctl.b_sel ? r_wi : r_wr;

  smag_mul_core #(.WIDTH(WIDTH)) u_core (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .i_start (r_mul_start),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_done  (w_mul_done),
    .o_sign  (w_mul_sign),
    .o_mag   (w_mul_mag)
  );

  // Negating a zero magnitude yields zero, so -0 operands add nothing
  assign w_neg     = w_mul_sign ^ w_ctl.sub;
  assign w_mag_ext = {{(OUT_W-PW){1'b0}}, w_mul_mag};
  assign w_term    = w_neg ? (~w_mag_ext + 1'b1) : w_mag_ext;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_ar        <= '0;
      r_ai        <= '0;
      r_wr        <= '0;
      r_wi        <= '0;
      r_re        <= '0;
      r_im        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_ar        <= ar;
            r_ai        <= ai;
            r_wr        <= wr;
            r_wi        <= wi;
            r_re        <= '0;
            r_im        <= '0;
            r_idx       <= 2'd0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_mul_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mul_start <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_mul_done) begin
            if (w_ctl.dst_im) r_im <= r_im + w_term;
            else              r_re <= r_re + w_term;
            if (r_idx == 2'd3) begin
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_idx       <= r_idx + 2'd1;
              r_mul_start <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          // Return through IDLE so a new request is never taken on the completion edge
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign re_out    = r_re;
  assign im_out    = r_im;

endmodule

// File: tb/tb_cmul_sched.sv
// tb/tb_cmul_sched.sv - directed and random checks of cmul_sched against an integer model
module tb_cmul_sched;

  localparam int WIDTH = 8;
  localparam int OUT_W = 2 * WIDTH;

  logic             clkin = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] ar = '0, ai = '0, wr = '0, wi = '0;
  logic             in_ready, out_valid, busy;
  logic [OUT_W-1:0] re_out, im_out;

  int n_cmp = 0;
  int n_bad = 0;

  cmul_sched #(.WIDTH(WIDTH)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ar        (ar),
    .ai        (ai),
    .wr        (wr),
    .wi        (wi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .re_out    (re_out),
    .im_out    (im_out),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2int(input logic [7:0] x);
    int m;
    m = int'(x[6:0]);
    return x[7] ? -m : m;
  endfunction

  function automatic int bitlen(input logic [7:0] x);
    int m;
    int n;
    m = int'(x[6:0]);
    n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  // One full request: accept, count latency, check results, optional backpressure, complete
  task automatic do_txn(input logic [7:0] a_r, input logic [7:0] a_i,
                        input logic [7:0] w_r, input logic [7:0] w_i,
                        input int hold, input bit keep_valid,
                        input logic [7:0] n_ar, input logic [7:0] n_ai,
                        input logic [7:0] n_wr, input logic [7:0] n_wi);
    int er, ei, lat, cyc;
    logic [15:0] e_re, e_im;
    er = sm2int(a_r) * sm2int(w_r) - sm2int(a_i) * sm2int(w_i);
    ei = sm2int(a_r) * sm2int(w_i) + sm2int(a_i) * sm2int(w_r);
    e_re = er[15:0];
    e_im = ei[15:0];
    lat = 2 * bitlen(w_r) + 2 * bitlen(w_i) + 8;

    ar = a_r; ai = a_i; wr = w_r; wi = w_i;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clkin); #1;
    chk("busy_accept", busy, 1);
    chk("in_ready_busy", in_ready, 0);
    ar = 8'($urandom); ai = 8'($urandom); wr = 8'($urandom); wi = 8'($urandom);

    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clkin); #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("re_out", re_out, e_re);
    chk("im_out", im_out, e_im);

    if (keep_valid) begin
      ar = n_ar; ai = n_ai; wr = n_wr; wi = n_wi;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clkin); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_re", re_out, e_re);
      chk("hold_im", im_out, e_im);
    end

    out_ready = 1'b1;
    @(posedge clkin); #1;
    out_ready = 1'b0;
    chk("done_valid_low", out_valid, 0);
    chk("done_busy_low", busy, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_re_kept", re_out, e_re);
  endtask

  initial begin
    int seen_valid;
    repeat (2) @(posedge clkin);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_re", re_out, 0);
    chk("rst_im", im_out, 0);
    @(posedge clkin); #1;

    do_txn(8'h02, 8'h01, 8'h03, 8'h00, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    do_txn(8'h05, 8'h83, 8'h84, 8'h07, 2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    do_txn(8'hFF, 8'hFF, 8'hFF, 8'h7F, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    do_txn(8'h09, 8'h89, 8'h80, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    do_txn(8'h05, 8'h83, 8'h84, 8'h07, 10, 1'b1, 8'h7F, 8'h81, 8'h0C, 8'hA5);
    do_txn(8'h7F, 8'h81, 8'h0C, 8'hA5, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset during WAIT of idx2: wr=6 (n=3), wi=13 (n=4), idx2 issued 11 edges after accept
    ar = 8'h0B; ai = 8'h85; wr = 8'h06; wi = 8'h0D;
    in_valid = 1'b1;
    @(posedge clkin); #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clkin);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_re", re_out, 0);
    chk("midrst_im", im_out, 0);
    repeat (2) @(posedge clkin);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clkin); #1;
      if (out_valid !== 1'b0) seen_valid++;
    end
    chk("midrst_no_valid", seen_valid, 0);
    do_txn(8'h0B, 8'h85, 8'h06, 8'h0D, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int t = 0; t < 16; t++) begin
      do_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
